alu_resp_unit: RTL

ALU_RESP_UNIT -- requirements
Module: alu_resp_unit

---
 rtl/alu_resp_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/alu_resp_unit.sv
// 8-bit ALU (add/sub/and/or) whose results are queued in a 2-entry output FIFO.
// Optional delivered-response counter enabled by defining ALU_RESP_STATS_EN.
module alu_resp_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [1:0]  ALU_Sel,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  ALU_Out,
    output logic        CarryOut,
    output logic [15:0] resp_count
);
    localparam logic [1:0] SEL_ADD = 2'd0;
    localparam logic [1:0] SEL_SUB = 2'd1;
    localparam logic [1:0] SEL_AND = 2'd2;

    // Each entry packs {carry, value}.
    logic [1:0][8:0] mem_q, mem_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic [8:0]      result;
    logic            push, pop;

    always_comb begin
        result = '0;
        case (ALU_Sel)
            SEL_ADD: result = {1'b0, A} + {1'b0, B};
            // Bit 8 of the 9-bit difference is the borrow (B > A).
            SEL_SUB: result = {1'b0, A} - {1'b0, B};
            SEL_AND: result = {1'b0, A & B};
            default: result = {1'b0, A | B};
        endcase
    end

    // Ready comes only from the registered count, never from resp_ready.
    assign req_ready  = !reset && (count_q != 2'd2);
    assign resp_valid = (count_q != 2'd0);
    assign push       = req_valid && req_ready;
    assign pop        = resp_valid && resp_ready;
    assign ALU_Out    = mem_q[rd_ptr_q][7:0];
    assign CarryOut   = mem_q[rd_ptr_q][8];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef ALU_RESP_STATS_EN
    logic [15:0] resp_count_q, resp_count_d;

    always_comb begin
        resp_count_d = resp_count_q;
        if (pop && (resp_count_q != 16'hFFFF)) begin
            resp_count_d = resp_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_count_q <= 16'd0;
        end else begin
            resp_count_q <= resp_count_d;
        end
    end

    assign resp_count = resp_count_q;
`else
    assign resp_count = 16'd0;
`endif

endmodule
